// File: rtl/gauss11_conv_mac.sv
// ----------------------------------------------------------------------------
// gauss11_conv_mac
//   Walks the 121 taps of an 11x11 Gaussian kernel. The coefficient ROM and the
//   pixel-window buffer are read in lockstep, and each pixel/coefficient product
//   is accumulated. The sum is then normalised by the kernel sum (1172) using a
//   reciprocal multiply and a shift. One saturated 8-bit pixel is presented on a
//   valid/ready handshake.
//
//   Optional feature: define ROUND_EN to round half up before the normalising
//   shift. Without it, the normalise step truncates. Saturation is always on.
//
// Ports
//   i_clk, i_rst       clock, synchronous active-high reset
//   i_start            run request, accepted only when idle
//   o_busy             high whenever not idle
//   o_coef_rd_en/addr  coefficient ROM read port (data on i_coef_data, +1 cycle)
//   o_pix_rd_en/addr   window buffer read port (data on i_pix_data, +1 cycle)
//   o_out_valid/data   result, held until i_out_ready
// ----------------------------------------------------------------------------
module gauss11_conv_mac #(
    parameter int PIX_W      = 8,
    parameter int COEF_W     = 24,
    parameter int TAPS       = 121,
    parameter int ADDR_W     = 7,
    parameter int ACC_W      = 40,
    parameter int NORM_MUL   = 895,
    parameter int NORM_SHIFT = 20
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    output logic              o_busy,
    output logic              o_coef_rd_en,
    output logic [ADDR_W-1:0] o_coef_addr,
    input  logic [COEF_W-1:0] i_coef_data,
    output logic              o_pix_rd_en,
    output logic [ADDR_W-1:0] o_pix_addr,
    input  logic [PIX_W-1:0]  i_pix_data,
    output logic              o_out_valid,
    input  logic              i_out_ready,
    output logic [PIX_W-1:0]  o_out_data
);

    localparam int PROD_W = PIX_W + COEF_W;
    // Headroom for acc * NORM_MUL plus the rounding term.
    localparam int T_W    = ACC_W + 12;

    localparam logic [T_W-1:0] PIX_MAX = T_W'((1 << PIX_W) - 1);
`ifdef ROUND_EN
    localparam logic [T_W-1:0] ROUND_ADD = T_W'(1) << (NORM_SHIFT - 1);
`else
    localparam logic [T_W-1:0] ROUND_ADD = '0;
`endif

    typedef enum logic [2:0] {S_IDLE, S_RUN, S_DRAIN, S_NORM, S_DONE} state_t;

    state_t            r_state;
    logic              r_busy;
    logic              r_rd_en;
    logic [ADDR_W-1:0] r_tap;
    logic              r_dv;       // read data valid, rd_en delayed one cycle
    logic [ACC_W-1:0]  r_acc;
    logic              r_out_valid;
    logic [PIX_W-1:0]  r_out_data;

    logic [PROD_W-1:0] w_prod;
    logic [T_W-1:0]    w_scaled;
    logic [T_W-1:0]    w_t;
    logic [PIX_W-1:0]  w_sat;

    assign w_prod   = PROD_W'(i_pix_data) * PROD_W'(i_coef_data);
    assign w_scaled = T_W'(r_acc) * T_W'(NORM_MUL) + ROUND_ADD;
    assign w_t      = w_scaled >> NORM_SHIFT;
    assign w_sat    = (w_t > PIX_MAX) ? PIX_MAX[PIX_W-1:0] : w_t[PIX_W-1:0];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= S_IDLE;
            r_busy      <= 1'b0;
            r_rd_en     <= 1'b0;
            r_tap       <= '0;
            r_dv        <= 1'b0;
            r_acc       <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else begin
            r_dv <= r_rd_en;
            // The product of the read issued last cycle is available now.
            // The final one lands on the DRAIN edge.
            if (r_dv)
                r_acc <= r_acc + ACC_W'(w_prod);

            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_state <= S_RUN;
                        r_busy  <= 1'b1;
                        r_rd_en <= 1'b1;
                        r_tap   <= '0;
                        r_acc   <= '0;
                    end
                end
                S_RUN: begin
                    if (r_tap == ADDR_W'(TAPS - 1)) begin
                        // The address stays at the last tap until the next start.
                        r_state <= S_DRAIN;
                        r_rd_en <= 1'b0;
                    end else begin
                        r_tap <= r_tap + 1'b1;
                    end
                end
                S_DRAIN: r_state <= S_NORM;
                S_NORM: begin
                    r_out_data <= w_sat;
                    r_state    <= S_DONE;
                end
                S_DONE: begin
                    // Spend one cycle here before raising valid. The data
                    // registered on the NORM edge is already stable by then.
                    if (!r_out_valid) begin
                        r_out_valid <= 1'b1;
                    end else if (i_out_ready) begin
                        r_out_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_busy       = r_busy;
    assign o_coef_rd_en = r_rd_en;
    assign o_coef_addr  = r_tap;
    assign o_pix_rd_en  = r_rd_en;
    assign o_pix_addr   = r_tap;
    assign o_out_valid  = r_out_valid;
    assign o_out_data   = r_out_data;

endmodule
